// File: rtl/mlcd_bus_arbiter.sv
// Intel 8080 LCD bus arbiter: command writes vs. atomic pixel bursts, with parameterised WR strobe timing.
// Optional HOLD-state watchdog enabled by defining MLCD_ARB_WDOG_EN.
module mlcd_bus_arbiter #(
    parameter int DW      = 16,
    parameter int WR_LOW  = 1,
    parameter int WR_HIGH = 1,
    parameter int TIMEOUT = 1024
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          lcd_init_done,
    input  logic          cmd_req,
    input  logic          cmd_rs,
    input  logic [DW-1:0] cmd_data,
    output logic          cmd_ack,
    input  logic          pix_valid,
    input  logic [DW-1:0] pix_data,
    input  logic          pix_last,
    output logic          pix_ready,
    output logic          grant_pix,
    output logic          busy,
    output logic          wdog_flag,
    output logic          mlcd_cs,
    output logic          mlcd_wr,
    output logic          mlcd_rs,
    output logic [DW-1:0] mlcd_data
);

    localparam int MAXW = (WR_LOW > WR_HIGH) ? WR_LOW : WR_HIGH;
    localparam int CW   = $clog2(MAXW) + 1;
    localparam logic [CW-1:0] LO_LOAD = CW'(WR_LOW - 1);
    localparam logic [CW-1:0] HI_LOAD = CW'(WR_HIGH - 1);

    if (WR_LOW < 1 || WR_HIGH < 1 || TIMEOUT < 1) begin : g_param_check
        $error("mlcd_bus_arbiter: WR_LOW, WR_HIGH and TIMEOUT must all be >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WR_LO = 2'd1,
        S_WR_HI = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          own_pix_q;
    logic          last_q;
    logic          cs_q;
    logic          wr_q;
    logic          rs_q;
    logic [DW-1:0] data_q;
    logic          ack_q;
    logic          grant_q;
    logic          pix_ready_d;

`ifdef MLCD_ARB_WDOG_EN
    localparam int WDW = $clog2(TIMEOUT) + 1;
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);
    logic [WDW-1:0] wcnt_q;
    logic           wdog_q;
`endif

    // The pixel side may hand over a beat in IDLE, on the last WR_HI cycle of a non-final beat, or in HOLD.
    always_comb begin
        pix_ready_d = 1'b0;
        case (state_q)
            S_IDLE:  pix_ready_d = lcd_init_done & ~cmd_req;
            S_WR_HI: pix_ready_d = own_pix_q & ~last_q & (cnt_q == '0);
            S_HOLD:  pix_ready_d = 1'b1;
            default: pix_ready_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            own_pix_q <= 1'b0;
            last_q    <= 1'b0;
            cs_q      <= 1'b1;
            wr_q      <= 1'b1;
            rs_q      <= 1'b0;
            data_q    <= '0;
            ack_q     <= 1'b0;
            grant_q   <= 1'b0;
`ifdef MLCD_ARB_WDOG_EN
            wcnt_q    <= '0;
            wdog_q    <= 1'b0;
`endif
        end else begin
            ack_q <= 1'b0;
`ifdef MLCD_ARB_WDOG_EN
            wdog_q <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    cs_q <= 1'b1;
                    wr_q <= 1'b1;
                    if (cmd_req) begin
                        rs_q      <= cmd_rs;
                        data_q    <= cmd_data;
                        own_pix_q <= 1'b0;
                        last_q    <= 1'b0;
                        cs_q      <= 1'b0;
                        wr_q      <= 1'b0;
                        cnt_q     <= LO_LOAD;
                        state_q   <= S_WR_LO;
                    end else if (pix_valid && lcd_init_done) begin
                        rs_q      <= 1'b1;
                        data_q    <= pix_data;
                        last_q    <= pix_last;
                        own_pix_q <= 1'b1;
                        grant_q   <= 1'b1;
                        cs_q      <= 1'b0;
                        wr_q      <= 1'b0;
                        cnt_q     <= LO_LOAD;
                        state_q   <= S_WR_LO;
                    end
                end
                S_WR_LO: begin
                    if (cnt_q == '0) begin
                        wr_q    <= 1'b1;
                        cnt_q   <= HI_LOAD;
                        state_q <= S_WR_HI;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                S_WR_HI: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CW'(1);
                    end else if (!own_pix_q) begin
                        ack_q   <= 1'b1;
                        cs_q    <= 1'b1;
                        state_q <= S_IDLE;
                    end else if (last_q) begin
                        grant_q   <= 1'b0;
                        own_pix_q <= 1'b0;
                        cs_q      <= 1'b1;
                        state_q   <= S_IDLE;
                    end else if (pix_valid) begin
                        data_q  <= pix_data;
                        last_q  <= pix_last;
                        wr_q    <= 1'b0;
                        cnt_q   <= LO_LOAD;
                        state_q <= S_WR_LO;
                    end else begin
`ifdef MLCD_ARB_WDOG_EN
                        wcnt_q  <= '0;
`endif
                        state_q <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    // Bus stays locked to the pixel stream; pending commands wait for the burst end.
                    if (pix_valid) begin
                        data_q  <= pix_data;
                        last_q  <= pix_last;
                        wr_q    <= 1'b0;
                        cnt_q   <= LO_LOAD;
                        state_q <= S_WR_LO;
`ifdef MLCD_ARB_WDOG_EN
                        wcnt_q  <= '0;
                    end else if (wcnt_q == WD_LAST) begin
                        grant_q   <= 1'b0;
                        own_pix_q <= 1'b0;
                        cs_q      <= 1'b1;
                        wdog_q    <= 1'b1;
                        wcnt_q    <= '0;
                        state_q   <= S_IDLE;
                    end else begin
                        wcnt_q <= wcnt_q + WDW'(1);
`endif
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cmd_ack   = ack_q;
    assign pix_ready = pix_ready_d;
    assign grant_pix = grant_q;
    assign busy      = (state_q != S_IDLE);
    assign mlcd_cs   = cs_q;
    assign mlcd_wr   = wr_q;
    assign mlcd_rs   = rs_q;
    assign mlcd_data = data_q;
`ifdef MLCD_ARB_WDOG_EN
    assign wdog_flag = wdog_q;
`else
    assign wdog_flag = 1'b0;
`endif

endmodule

// File: tb/tb_mlcd_bus_arbiter.sv
// Directed bench for mlcd_bus_arbiter: instance A uses WR_LOW=2/WR_HIGH=1/TIMEOUT=8, instance B uses 1/1/1024.
// Control bits are compared as {cs, wr, rs, grant_pix, busy, cmd_ack}.
module tb_mlcd_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        lcd_init_done;
    logic        cmd_req;
    logic        cmd_rs;
    logic [15:0] cmd_data;
    logic        pix_valid;
    logic [15:0] pix_data;
    logic        pix_last;

    logic        a_ack, a_ready, a_grant, a_busy, a_wdog, a_cs, a_wr, a_rs;
    logic [15:0] a_data;
    logic        b_ack, b_ready, b_grant, b_busy, b_wdog, b_cs, b_wr, b_rs;
    logic [15:0] b_data;

    wire  [5:0]  a_ctl = {a_cs, a_wr, a_rs, a_grant, a_busy, a_ack};
    wire  [5:0]  b_ctl = {b_cs, b_wr, b_rs, b_grant, b_busy, b_ack};

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    mlcd_bus_arbiter #(.DW(16), .WR_LOW(2), .WR_HIGH(1), .TIMEOUT(8)) dut_a (
        .clk(clk), .rst(rst), .lcd_init_done(lcd_init_done),
        .cmd_req(cmd_req), .cmd_rs(cmd_rs), .cmd_data(cmd_data), .cmd_ack(a_ack),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_last(pix_last), .pix_ready(a_ready),
        .grant_pix(a_grant), .busy(a_busy), .wdog_flag(a_wdog),
        .mlcd_cs(a_cs), .mlcd_wr(a_wr), .mlcd_rs(a_rs), .mlcd_data(a_data)
    );

    mlcd_bus_arbiter #(.DW(16), .WR_LOW(1), .WR_HIGH(1), .TIMEOUT(1024)) dut_b (
        .clk(clk), .rst(rst), .lcd_init_done(lcd_init_done),
        .cmd_req(cmd_req), .cmd_rs(cmd_rs), .cmd_data(cmd_data), .cmd_ack(b_ack),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_last(pix_last), .pix_ready(b_ready),
        .grant_pix(b_grant), .busy(b_busy), .wdog_flag(b_wdog),
        .mlcd_cs(b_cs), .mlcd_wr(b_wr), .mlcd_rs(b_rs), .mlcd_data(b_data)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        lcd_init_done = 1'b0;
        cmd_req = 1'b0;
        cmd_rs = 1'b0;
        cmd_data = 16'h0000;
        pix_valid = 1'b0;
        pix_data = 16'h0000;
        pix_last = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        nvec++; if (a_ctl !== 6'b110000) begin nerr++; $display("FAIL reset_a_ctl got=%b exp=%b", a_ctl, 6'b110000); end
        nvec++; if (a_data !== 16'h0000) begin nerr++; $display("FAIL reset_a_data got=%h exp=%h", a_data, 16'h0000); end
        nvec++; if (a_wdog !== 1'b0) begin nerr++; $display("FAIL reset_a_wdog got=%b exp=0", a_wdog); end
        nvec++; if (a_ready !== 1'b0) begin nerr++; $display("FAIL reset_a_ready got=%b exp=0", a_ready); end
        nvec++; if (b_ctl !== 6'b110000) begin nerr++; $display("FAIL reset_b_ctl got=%b exp=%b", b_ctl, 6'b110000); end
    endtask

    task automatic test_cmd_write;
        do_reset();
        cmd_req = 1'b1; cmd_rs = 1'b0; cmd_data = 16'h002C;
        tick();
        nvec++; if (a_ctl !== 6'b000010) begin nerr++; $display("FAIL cmd_c1 got=%b exp=%b", a_ctl, 6'b000010); end
        nvec++; if (a_data !== 16'h002C) begin nerr++; $display("FAIL cmd_data got=%h exp=%h", a_data, 16'h002C); end
        tick();
        nvec++; if (a_ctl !== 6'b000010) begin nerr++; $display("FAIL cmd_c2 got=%b exp=%b", a_ctl, 6'b000010); end
        tick();
        nvec++; if (a_ctl !== 6'b010010) begin nerr++; $display("FAIL cmd_c3 got=%b exp=%b", a_ctl, 6'b010010); end
        tick();
        nvec++; if (a_ctl !== 6'b110001) begin nerr++; $display("FAIL cmd_ack_c4 got=%b exp=%b", a_ctl, 6'b110001); end
        cmd_req = 1'b0;
        tick();
        nvec++; if (a_ctl !== 6'b110000) begin nerr++; $display("FAIL cmd_ack_pulse got=%b exp=%b", a_ctl, 6'b110000); end
    endtask

    task automatic test_priority;
        do_reset();
        lcd_init_done = 1'b1;
        cmd_req = 1'b1; cmd_rs = 1'b1; cmd_data = 16'hABCD;
        pix_valid = 1'b1; pix_data = 16'h5555; pix_last = 1'b1;
        #1;
        nvec++; if (b_ready !== 1'b0) begin nerr++; $display("FAIL prio_ready got=%b exp=0", b_ready); end
        tick();
        nvec++; if (b_ctl !== 6'b001010) begin nerr++; $display("FAIL prio_cmd_lo got=%b exp=%b", b_ctl, 6'b001010); end
        nvec++; if (b_data !== 16'hABCD) begin nerr++; $display("FAIL prio_cmd_data got=%h exp=%h", b_data, 16'hABCD); end
        tick();
        nvec++; if (b_ctl !== 6'b011010) begin nerr++; $display("FAIL prio_cmd_hi got=%b exp=%b", b_ctl, 6'b011010); end
        tick();
        nvec++; if (b_ctl !== 6'b111001) begin nerr++; $display("FAIL prio_cmd_ack got=%b exp=%b", b_ctl, 6'b111001); end
        cmd_req = 1'b0;
        #1;
        nvec++; if (b_ready !== 1'b1) begin nerr++; $display("FAIL prio_ready_idle got=%b exp=1", b_ready); end
        tick();
        nvec++; if (b_ctl !== 6'b001110) begin nerr++; $display("FAIL prio_pix_lo got=%b exp=%b", b_ctl, 6'b001110); end
        nvec++; if (b_data !== 16'h5555) begin nerr++; $display("FAIL prio_pix_data got=%h exp=%h", b_data, 16'h5555); end
        pix_valid = 1'b0; pix_last = 1'b0;
        tick();
        nvec++; if (b_ctl !== 6'b011110) begin nerr++; $display("FAIL prio_pix_hi got=%b exp=%b", b_ctl, 6'b011110); end
        tick();
        nvec++; if (b_ctl !== 6'b111000) begin nerr++; $display("FAIL prio_pix_end got=%b exp=%b", b_ctl, 6'b111000); end
    endtask

    task automatic test_stream;
        logic [15:0] beats [4];
        beats[0] = 16'h1111; beats[1] = 16'h2222; beats[2] = 16'h3333; beats[3] = 16'h4444;
        do_reset();
        lcd_init_done = 1'b1;
        pix_valid = 1'b1; pix_data = beats[0]; pix_last = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            nvec++; if (b_ctl !== 6'b001110) begin nerr++; $display("FAIL stream_lo%0d got=%b exp=%b", i, b_ctl, 6'b001110); end
            nvec++; if (b_data !== beats[i]) begin nerr++; $display("FAIL stream_data%0d got=%h exp=%h", i, b_data, beats[i]); end
            if (i < 3) begin
                pix_data = beats[i+1];
                pix_last = (i == 2);
            end else begin
                pix_valid = 1'b0;
                pix_last = 1'b0;
            end
            tick();
            nvec++; if (b_ctl !== 6'b011110) begin nerr++; $display("FAIL stream_hi%0d got=%b exp=%b", i, b_ctl, 6'b011110); end
            nvec++; if (b_ready !== (i < 3)) begin nerr++; $display("FAIL stream_ready%0d got=%b exp=%b", i, b_ready, (i < 3)); end
        end
        tick();
        nvec++; if (b_ctl !== 6'b111000) begin nerr++; $display("FAIL stream_end got=%b exp=%b", b_ctl, 6'b111000); end
    endtask

    task automatic test_hold_cmd_blocked;
        do_reset();
        lcd_init_done = 1'b1;
        pix_valid = 1'b1; pix_data = 16'h1111; pix_last = 1'b0;
        tick();
        pix_data = 16'h2222;
        tick();
        tick();
        nvec++; if (b_data !== 16'h2222) begin nerr++; $display("FAIL hold_beat2 got=%h exp=%h", b_data, 16'h2222); end
        pix_valid = 1'b0;
        cmd_req = 1'b1; cmd_rs = 1'b0; cmd_data = 16'h2C00;
        tick();
        nvec++; if (b_ctl !== 6'b011110) begin nerr++; $display("FAIL hold_b2_hi got=%b exp=%b", b_ctl, 6'b011110); end
        tick();
        nvec++; if (b_ready !== 1'b1) begin nerr++; $display("FAIL hold_ready got=%b exp=1", b_ready); end
        for (int k = 0; k < 10; k++) begin
            nvec++; if (b_ctl !== 6'b011110) begin nerr++; $display("FAIL hold_gap%0d got=%b exp=%b", k, b_ctl, 6'b011110); end
            tick();
        end
        pix_valid = 1'b1; pix_data = 16'h3333; pix_last = 1'b1;
        tick();
        nvec++; if (b_ctl !== 6'b001110) begin nerr++; $display("FAIL hold_b3_lo got=%b exp=%b", b_ctl, 6'b001110); end
        nvec++; if (b_data !== 16'h3333) begin nerr++; $display("FAIL hold_b3_data got=%h exp=%h", b_data, 16'h3333); end
        pix_valid = 1'b0; pix_last = 1'b0;
        tick();
        tick();
        nvec++; if (b_ctl !== 6'b111000) begin nerr++; $display("FAIL hold_burst_end got=%b exp=%b", b_ctl, 6'b111000); end
        tick();
        nvec++; if (b_ctl !== 6'b000010) begin nerr++; $display("FAIL hold_cmd_lo got=%b exp=%b", b_ctl, 6'b000010); end
        nvec++; if (b_data !== 16'h2C00) begin nerr++; $display("FAIL hold_cmd_data got=%h exp=%h", b_data, 16'h2C00); end
        tick();
        tick();
        nvec++; if (b_ctl !== 6'b110001) begin nerr++; $display("FAIL hold_cmd_ack got=%b exp=%b", b_ctl, 6'b110001); end
        cmd_req = 1'b0;
    endtask

    task automatic test_init_gate;
        do_reset();
        lcd_init_done = 1'b0;
        pix_valid = 1'b1; pix_data = 16'h0F0F; pix_last = 1'b0;
        #1;
        nvec++; if (b_ready !== 1'b0) begin nerr++; $display("FAIL gate_ready got=%b exp=0", b_ready); end
        for (int k = 0; k < 3; k++) begin
            tick();
            nvec++; if (b_ctl !== 6'b110000) begin nerr++; $display("FAIL gate_idle%0d got=%b exp=%b", k, b_ctl, 6'b110000); end
        end
        lcd_init_done = 1'b1;
        tick();
        nvec++; if (b_ctl !== 6'b001110) begin nerr++; $display("FAIL gate_start got=%b exp=%b", b_ctl, 6'b001110); end
        lcd_init_done = 1'b0;
        pix_data = 16'hF0F0; pix_last = 1'b1;
        tick();
        nvec++; if (b_ready !== 1'b1) begin nerr++; $display("FAIL gate_mid_ready got=%b exp=1", b_ready); end
        tick();
        nvec++; if (b_data !== 16'hF0F0) begin nerr++; $display("FAIL gate_mid_data got=%h exp=%h", b_data, 16'hF0F0); end
        pix_valid = 1'b0; pix_last = 1'b0;
        tick();
        tick();
        nvec++; if (b_ctl !== 6'b111000) begin nerr++; $display("FAIL gate_end got=%b exp=%b", b_ctl, 6'b111000); end
    endtask

    task automatic test_watchdog;
        do_reset();
        lcd_init_done = 1'b1;
        pix_valid = 1'b1; pix_data = 16'h7777; pix_last = 1'b0;
        tick();
        nvec++; if (a_ctl !== 6'b001110) begin nerr++; $display("FAIL wd_lo got=%b exp=%b", a_ctl, 6'b001110); end
        pix_valid = 1'b0;
        tick();
        tick();
        tick();
        nvec++; if (a_ctl !== 6'b011110) begin nerr++; $display("FAIL wd_hold_entry got=%b exp=%b", a_ctl, 6'b011110); end
        cmd_req = 1'b1; cmd_rs = 1'b1; cmd_data = 16'h0001;
`ifdef MLCD_ARB_WDOG_EN
        for (int k = 0; k < 7; k++) begin
            tick();
            nvec++; if (a_ctl !== 6'b011110 || a_wdog !== 1'b0) begin nerr++; $display("FAIL wd_hold%0d ctl=%b wdog=%b exp ctl=%b wdog=0", k, a_ctl, a_wdog, 6'b011110); end
        end
        tick();
        nvec++; if (a_ctl !== 6'b111000 || a_wdog !== 1'b1) begin nerr++; $display("FAIL wd_release ctl=%b wdog=%b exp ctl=%b wdog=1", a_ctl, a_wdog, 6'b111000); end
        tick();
        nvec++; if (a_ctl !== 6'b001010 || a_wdog !== 1'b0) begin nerr++; $display("FAIL wd_cmd_wins ctl=%b wdog=%b exp ctl=%b wdog=0", a_ctl, a_wdog, 6'b001010); end
        nvec++; if (a_data !== 16'h0001) begin nerr++; $display("FAIL wd_cmd_data got=%h exp=%h", a_data, 16'h0001); end
        tick();
        tick();
        tick();
        nvec++; if (a_ctl !== 6'b111001) begin nerr++; $display("FAIL wd_cmd_ack got=%b exp=%b", a_ctl, 6'b111001); end
`else
        for (int k = 0; k < 20; k++) begin
            tick();
            nvec++; if (a_ctl !== 6'b011110 || a_wdog !== 1'b0) begin nerr++; $display("FAIL wd_off_hold%0d ctl=%b wdog=%b exp ctl=%b wdog=0", k, a_ctl, a_wdog, 6'b011110); end
        end
        pix_valid = 1'b1; pix_data = 16'h7778; pix_last = 1'b1;
        tick();
        pix_valid = 1'b0; pix_last = 1'b0;
        tick();
        tick();
        tick();
        nvec++; if (a_ctl !== 6'b111000) begin nerr++; $display("FAIL wd_off_end got=%b exp=%b", a_ctl, 6'b111000); end
        tick();
        nvec++; if (a_ctl !== 6'b001010) begin nerr++; $display("FAIL wd_off_cmd got=%b exp=%b", a_ctl, 6'b001010); end
`endif
        cmd_req = 1'b0;
    endtask

    task automatic test_reset_mid;
        do_reset();
        cmd_req = 1'b1; cmd_rs = 1'b1; cmd_data = 16'h1234;
        tick();
        nvec++; if (a_ctl !== 6'b001010) begin nerr++; $display("FAIL rmid_wrlo got=%b exp=%b", a_ctl, 6'b001010); end
        rst = 1'b1;
        tick();
        nvec++; if (a_ctl !== 6'b110000) begin nerr++; $display("FAIL rmid_ctl got=%b exp=%b", a_ctl, 6'b110000); end
        nvec++; if (a_data !== 16'h0000) begin nerr++; $display("FAIL rmid_data got=%h exp=%h", a_data, 16'h0000); end
        cmd_req = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        nvec++; if (a_ctl !== 6'b110000) begin nerr++; $display("FAIL rmid_no_ack got=%b exp=%b", a_ctl, 6'b110000); end
        lcd_init_done = 1'b1;
        pix_valid = 1'b1; pix_data = 16'hABAB; pix_last = 1'b0;
        tick();
        nvec++; if (b_ctl !== 6'b001110) begin nerr++; $display("FAIL rmid_pix_lo got=%b exp=%b", b_ctl, 6'b001110); end
        rst = 1'b1;
        tick();
        nvec++; if (b_ctl !== 6'b110000 || b_data !== 16'h0000) begin nerr++; $display("FAIL rmid_pix ctl=%b data=%h exp ctl=%b data=0000", b_ctl, b_data, 6'b110000); end
        rst = 1'b0;
        pix_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_cmd_write();
        test_priority();
        test_stream();
        test_hold_cmd_blocked();
        test_init_gate();
        test_watchdog();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL tb_time_limit reached before summary");
        $fatal(1);
    end

endmodule
